// File: rtl/udp_frame_sender_pkg.sv
// Shared definitions for the UDP frame sender: FSM encoding, default sizing
// and the header length.
package udp_frame_sender_pkg;

  localparam int DEF_PKT_WORDS = 256;
  localparam int DEF_IFG       = 12;
  localparam int HDR_BYTES     = 4;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HDR  = 3'd1,
    REQ  = 3'd2,
    WAIT = 3'd3,
    SEND = 3'd4,
    GAP  = 3'd5,
    FIN  = 3'd6
  } state_t;

endpackage

// File: rtl/udp_frame_sender_if.sv
// SDRAM read port and byte stream towards the UDP MAC.
// Byte stream: a byte moves on a rising clk edge where tx_valid and tx_ready
// are both high; while tx_valid is high and tx_ready low, tx_data/tx_sop/tx_eop
// hold their value, and tx_valid never drops before the transfer.
interface udp_frame_sender_if;
  logic        mem_rd_req;
  logic [15:0] mem_rd_addr;
  logic        mem_rd_valid;
  logic [31:0] mem_rd_data;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        tx_sop;
  logic        tx_eop;

  modport master (
    output mem_rd_req, mem_rd_addr, tx_data, tx_valid, tx_sop, tx_eop,
    input  mem_rd_valid, mem_rd_data, tx_ready
  );

  modport slave (
    input  mem_rd_req, mem_rd_addr, tx_data, tx_valid, tx_sop, tx_eop,
    output mem_rd_valid, mem_rd_data, tx_ready
  );
endinterface

// File: rtl/udp_byte_serializer.sv
// Turns one 32-bit word into four bytes, MSB first, over a valid/ready stream.
// A load is taken only while empty; sop/eop tag the first/last byte of the word.
module udp_byte_serializer
  import udp_frame_sender_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] in_data,
  input  logic        in_sop,
  input  logic        in_eop,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_sop,
  output logic        out_eop,
  output logic        word_done
);
  localparam logic [1:0] LAST_IDX = 2'(HDR_BYTES - 1);

  logic [31:0] shreg;
  logic [1:0]  idx;
  logic        full;
  logic        sop_q;
  logic        eop_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg <= '0;
      idx   <= '0;
      full  <= 1'b0;
      sop_q <= 1'b0;
      eop_q <= 1'b0;
    end else if (!full) begin
      if (load) begin
        shreg <= in_data;
        sop_q <= in_sop;
        eop_q <= in_eop;
        idx   <= '0;
        full  <= 1'b1;
      end
    end else if (out_ready) begin
      if (idx == LAST_IDX) begin
        full <= 1'b0;
      end else begin
        shreg <= {shreg[23:0], 8'h00};
        idx   <= idx + 2'd1;
      end
    end
  end

  assign out_valid = full;
  assign out_data  = full ? shreg[31:24] : 8'h00;
  assign out_sop   = full & sop_q & (idx == 2'd0);
  assign out_eop   = full & eop_q & (idx == LAST_IDX);
  assign word_done = full & out_ready & (idx == LAST_IDX);

endmodule

// File: rtl/udp_frame_sender.sv
// Reads a word range from SDRAM and sends it as one or more packets, each led by
// a 4-byte big-endian sequence number, with a fixed idle gap between packets.
module udp_frame_sender
  import udp_frame_sender_pkg::*;
#(
  parameter int PKT_WORDS = DEF_PKT_WORDS,
  parameter int IFG       = DEF_IFG
) (
  input  logic                      clk,
  input  logic                      RST,
  input  logic                      packet_start,
  input  logic [15:0]               rdaddr_begin,
  input  logic [15:0]               rdaddr_end,
  input  logic [15:0]               frame_length,
  input  logic [31:0]               cnt_init,
  udp_frame_sender_if.master        bus,
  output logic                      busy,
  output logic                      done,
  output logic                      len_err,
  output state_t                    state_dbg
);
  localparam logic [15:0] PKT_LIM  = 16'(PKT_WORDS);
  localparam logic [15:0] GAP_LAST = 16'(IFG - 1);

  state_t      state, state_nxt;
  logic        ps_q;
  logic        trig;
  logic [15:0] n_words;
  logic [16:0] exp_bytes;
  logic [15:0] addr, remaining, pkt_left, gap_cnt;
  logic [31:0] seq, word_buf;
  logic        ser_load, ser_sop, ser_eop, word_done;
  logic [31:0] ser_word;

  assign trig      = packet_start & ~ps_q;
  assign n_words   = rdaddr_end - rdaddr_begin;
  assign exp_bytes = {n_words[14:0], 2'b00};

  always_ff @(posedge clk or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  // The next header is loaded in the last GAP cycle so sop follows exactly IFG idle clocks.
  always_comb begin
    state_nxt = state;
    ser_load  = 1'b0;
    ser_word  = seq;
    ser_sop   = 1'b0;
    ser_eop   = 1'b0;
    case (state)
      IDLE: if (trig) state_nxt = (n_words == 16'd0) ? FIN : HDR;
      HDR: begin
        ser_load = 1'b1;
        ser_sop  = 1'b1;
        if (word_done) state_nxt = REQ;
      end
      REQ:  state_nxt = WAIT;
      WAIT: if (bus.mem_rd_valid) state_nxt = SEND;
      SEND: begin
        ser_load = 1'b1;
        ser_word = word_buf;
        ser_eop  = (pkt_left == 16'd1);
        if (word_done) begin
          if (pkt_left != 16'd1)        state_nxt = REQ;
          else if (remaining == 16'd1)  state_nxt = FIN;
          else                          state_nxt = (IFG == 0) ? HDR : GAP;
        end
      end
      GAP: if (gap_cnt == GAP_LAST) begin
        ser_load  = 1'b1;
        ser_sop   = 1'b1;
        state_nxt = HDR;
      end
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      ps_q      <= 1'b1;
      addr      <= '0;
      remaining <= '0;
      pkt_left  <= '0;
      gap_cnt   <= '0;
      seq       <= '0;
      word_buf  <= '0;
    end else begin
      ps_q <= packet_start;
      case (state)
        IDLE: if (trig) begin
          addr      <= rdaddr_begin;
          remaining <= n_words;
          seq       <= cnt_init;
        end
        HDR: if (word_done) pkt_left <= (remaining > PKT_LIM) ? PKT_LIM : remaining;
        REQ:  addr <= addr + 16'd1;
        WAIT: if (bus.mem_rd_valid) word_buf <= bus.mem_rd_data;
        SEND: if (word_done) begin
          remaining <= remaining - 16'd1;
          pkt_left  <= pkt_left - 16'd1;
          gap_cnt   <= '0;
          if (pkt_left == 16'd1) seq <= seq + 32'd1;
        end
        GAP: gap_cnt <= gap_cnt + 16'd1;
        default: ;
      endcase
    end
  end

  udp_byte_serializer u_ser (
    .clk       (clk),
    .rst       (RST),
    .load      (ser_load),
    .in_data   (ser_word),
    .in_sop    (ser_sop),
    .in_eop    (ser_eop),
    .out_data  (bus.tx_data),
    .out_valid (bus.tx_valid),
    .out_ready (bus.tx_ready),
    .out_sop   (bus.tx_sop),
    .out_eop   (bus.tx_eop),
    .word_done (word_done)
  );

  assign bus.mem_rd_req  = (state == REQ);
  assign bus.mem_rd_addr = addr;
  assign busy            = state inside {HDR, REQ, WAIT, SEND, GAP};
  assign done            = (state == FIN);
  assign len_err         = (state == IDLE) & trig & ({1'b0, frame_length} != exp_bytes);
  assign state_dbg       = state;

endmodule

// File: doc/udp_frame_sender.md
UDP_FRAME_SENDER -- requirements
Module: udp_frame_sender

Interface
REQ-001 Parameter PKT_WORDS, default 256: maximum payload words (32-bit) per packet.
REQ-002 Parameter IFG, default 12: idle clocks between consecutive packets.
REQ-003 clk  in  1  sole clock; all logic on its rising edge.
REQ-004 RST  in  1  reset, asynchronous, active-high.
REQ-005 packet_start  in  1  level request; its rising edge starts a transfer.
REQ-006 rdaddr_begin  in  16  first SDRAM word address, inclusive.
REQ-007 rdaddr_end  in  16  end SDRAM word address, exclusive.
REQ-008 frame_length  in  16  expected byte count; checked only.
REQ-009 cnt_init  in  32  initial packet sequence number.
REQ-010 mem_rd_req  out  1  one-cycle SDRAM word read strobe.
REQ-011 mem_rd_addr  out  16  address for mem_rd_req.
REQ-012 mem_rd_valid  in  1  read data valid, at least 1 cycle after mem_rd_req.
REQ-013 mem_rd_data  in  32  read word.
REQ-014 tx_data  out  8  byte stream to the UDP MAC.
REQ-015 tx_valid  out  1  tx_data valid.
REQ-016 tx_ready  in  1  MAC accepts the byte.
REQ-017 tx_sop / tx_eop  out  1 each  first / last byte of a packet, qualified by tx_valid.
REQ-018 busy  out  1  transfer in progress.
REQ-019 done  out  1  one-cycle pulse at transfer end.
REQ-020 len_err  out  1  one-cycle pulse on length mismatch.

Function
REQ-021 Trigger: packet_start registered once; rising edge = current high AND registered value low.
REQ-022 In IDLE, a trigger latches begin, end, frame_length and cnt_init, then sets busy the next cycle.
REQ-023 Triggers while busy are ignored and are not queued.
REQ-024 Word count N = rdaddr_end - rdaddr_begin, modulo 2^16.
REQ-025 N = 0: no memory reads, no bytes sent; done pulses 1 cycle after the trigger; busy stays low.
REQ-026 If frame_length != 4*N (17-bit compare), len_err pulses in the trigger-latch cycle and the transfer still proceeds.
REQ-027 FSM states: IDLE, HDR, REQ, WAIT, SEND, GAP, FIN.
REQ-028 HDR sends 4 bytes of the sequence number, MSB first; the first byte carries tx_sop.
REQ-029 REQ issues exactly one mem_rd_req at the current address, then moves to WAIT.
REQ-030 WAIT holds until mem_rd_valid, captures mem_rd_data into a 32-bit buffer, then moves to SEND.
REQ-031 SEND emits the 4 buffered bytes MSB first; only one read is ever outstanding.
REQ-032 Packet payload = min(remaining, PKT_WORDS) words; tx_eop is on the last byte of the last word.
REQ-033 After each packet: sequence += 1 (wraps at 2^32); if words remain, go to GAP for IFG cycles, then HDR; otherwise go to FIN.
REQ-034 FIN: done pulses, busy clears, return to IDLE.
REQ-035 A byte transfers when tx_valid AND tx_ready are both high; tx_data, tx_sop and tx_eop stay stable while tx_valid is high and tx_ready is low.
REQ-036 tx_valid is low in IDLE, REQ, WAIT, GAP and FIN.
REQ-037 mem_rd_addr increments modulo 2^16, so the range may wrap past 0xFFFF.
REQ-038 mem_rd_valid outside WAIT is ignored.

Reset
REQ-039 RST asserted at any time, including mid-packet, forces IDLE immediately.
REQ-040 Reset values: all outputs 0, sequence 0, buffer 0, counters 0.
REQ-041 The packet_start edge register resets to 1, so a level held high through reset does not trigger.

Structure
REQ-042 A shared package holds the state encoding, PKT_WORDS/IFG defaults and the header byte count (4).
REQ-043 One sub-module, udp_byte_serializer, does the 32-bit to 4-byte serialization with ready/valid.

Verification
REQ-044 begin=0x0010, end=0x0014, frame_length=16, cnt_init=0x12345678, tx_ready=1 -> one packet of 20 bytes: header 12 34 56 78, then 4 words MSB first; sop on byte 0, eop on byte 19; done pulses once.
REQ-045 N=600 with PKT_WORDS=256 -> packets of 256, 256 and 88 words; sequence numbers cnt_init, +1, +2; exactly 12 idle cycles between packets.
REQ-046 begin=0xFFFE, end=0x0002 -> addresses FFFE, FFFF, 0000, 0001 requested.
REQ-047 Random tx_ready deassertion and 1-7 cycle read latency -> byte stream identical to the no-stall case; outputs stable while stalled.
REQ-048 begin=end -> done 1 cycle after trigger, no tx_valid; frame_length=8 with N=4 -> len_err pulse.
REQ-049 RST mid-payload -> all outputs 0 the same cycle; a new trigger afterwards starts a clean header.
